// File: rtl/display_frame_latch.sv
// -----------------------------------------------------------------------------
// display_frame_latch
//
// Frame-synchronous snapshot stage in front of the VGA controller. It takes
// elevator display state through a valid/ready handshake and holds one pending
// update. The pending update is copied to the VGA-facing outputs only at the
// start of the vertical sync pulse, so a frame is never drawn from two
// different states. It also produces frame-rate timing for display animation.
//
// Ports:
//   pixel_clk        sole clock (rising edge)
//   reset            synchronous, active-high
//   upd_valid        producer offers an update
//   upd_ready        block can accept an update (registered)
//   upd_destination  offered destination
//   upd_people_data  offered passenger bitmap
//   upd_sim_state    offered simulation state
//   vsync            active-low vertical sync from the VGA controller
//   destination      committed destination
//   people_data      committed passenger bitmap
//   sim_state        committed simulation state
//   frame_count      frames since reset, wraps at 256
//   blink            toggles every BLINK_FRAMES frames
//   stale_frames     frames since the last commit, saturates at 255
// -----------------------------------------------------------------------------
module display_frame_latch #(
   parameter int DEST_W       = 8,
   parameter int PEOPLE_W     = 26,
   parameter int STATE_W      = 2,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                pixel_clk,
   input  logic                reset,
   input  logic                upd_valid,
   output logic                upd_ready,
   input  logic [DEST_W-1:0]   upd_destination,
   input  logic [PEOPLE_W-1:0] upd_people_data,
   input  logic [STATE_W-1:0]  upd_sim_state,
   input  logic                vsync,
   output logic [DEST_W-1:0]   destination,
   output logic [PEOPLE_W-1:0] people_data,
   output logic [STATE_W-1:0]  sim_state,
   output logic [7:0]          frame_count,
   output logic                blink,
   output logic [7:0]          stale_frames
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_t;

   buf_state_t          state_q, state_d;
   logic                upd_ready_q, upd_ready_d;
   logic                vsync_q, vsync_d;

   logic [DEST_W-1:0]   buf_dest_q, buf_dest_d;
   logic [PEOPLE_W-1:0] buf_people_q, buf_people_d;
   logic [STATE_W-1:0]  buf_sim_state_q, buf_sim_state_d;

   logic [DEST_W-1:0]   dest_q, dest_d;
   logic [PEOPLE_W-1:0] people_q, people_d;
   logic [STATE_W-1:0]  sim_state_q, sim_state_d;

   logic [7:0]          frame_count_q, frame_count_d;
   logic [7:0]          blink_cnt_q, blink_cnt_d;
   logic                blink_q, blink_d;
   logic [7:0]          stale_q, stale_d;

   logic                frame_start;
   logic                commit;
   logic [8:0]          blink_cnt_inc;

   // Falling edge of vsync as seen against the previous sample; a long low
   // pulse yields a single frame_start because vsync_q follows vsync low.
   assign frame_start   = vsync_q & ~vsync;
   assign blink_cnt_inc = {1'b0, blink_cnt_q} + 9'd1;

   always_comb begin
      state_d         = state_q;
      vsync_d         = vsync;
      buf_dest_d      = buf_dest_q;
      buf_people_d    = buf_people_q;
      buf_sim_state_d = buf_sim_state_q;
      dest_d          = dest_q;
      people_d        = people_q;
      sim_state_d     = sim_state_q;
      frame_count_d   = frame_count_q;
      blink_cnt_d     = blink_cnt_q;
      blink_d         = blink_q;
      stale_d         = stale_q;
      commit          = 1'b0;

      case (state_q)
         ST_EMPTY: begin
            // Accept gated by the registered ready so the handshake seen by
            // the producer is exactly what the buffer acts on. No bypass: an
            // accept coinciding with frame_start waits for the next frame.
            if (upd_valid && upd_ready_q) begin
               buf_dest_d      = upd_destination;
               buf_people_d    = upd_people_data;
               buf_sim_state_d = upd_sim_state;
               state_d         = ST_FULL;
            end
         end
         ST_FULL: begin
            if (frame_start) begin
               dest_d      = buf_dest_q;
               people_d    = buf_people_q;
               sim_state_d = buf_sim_state_q;
               commit      = 1'b1;
               state_d     = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Ready tracks the state being entered, so it is high in the cycle
      // right after a commit.
      upd_ready_d = (state_d == ST_EMPTY);

      if (frame_start) begin
         frame_count_d = frame_count_q + 8'd1;

         if (blink_cnt_inc == 9'(BLINK_FRAMES)) begin
            blink_cnt_d = 8'd0;
            blink_d     = ~blink_q;
         end else begin
            blink_cnt_d = blink_cnt_inc[7:0];
         end

         if (commit) begin
            stale_d = 8'd0;
         end else if (stale_q != 8'hFF) begin
            stale_d = stale_q + 8'd1;
         end
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         state_q         <= ST_EMPTY;
         upd_ready_q     <= 1'b0;
         vsync_q         <= 1'b1;
         buf_dest_q      <= '0;
         buf_people_q    <= '0;
         buf_sim_state_q <= '0;
         dest_q          <= '0;
         people_q        <= '0;
         sim_state_q     <= '0;
         frame_count_q   <= 8'd0;
         blink_cnt_q     <= 8'd0;
         blink_q         <= 1'b0;
         stale_q         <= 8'd0;
      end else begin
         state_q         <= state_d;
         upd_ready_q     <= upd_ready_d;
         vsync_q         <= vsync_d;
         buf_dest_q      <= buf_dest_d;
         buf_people_q    <= buf_people_d;
         buf_sim_state_q <= buf_sim_state_d;
         dest_q          <= dest_d;
         people_q        <= people_d;
         sim_state_q     <= sim_state_d;
         frame_count_q   <= frame_count_d;
         blink_cnt_q     <= blink_cnt_d;
         blink_q         <= blink_d;
         stale_q         <= stale_d;
      end
   end

   assign upd_ready    = upd_ready_q;
   assign destination  = dest_q;
   assign people_data  = people_q;
   assign sim_state    = sim_state_q;
   assign frame_count  = frame_count_q;
   assign blink        = blink_q;
   assign stale_frames = stale_q;

endmodule

// File: tb/tb_display_frame_latch.sv
// -----------------------------------------------------------------------------
// tb_display_frame_latch
//
// Self-checking bench for display_frame_latch. A transaction-level model
// (one-entry pending slot, frame totals, frames-since-commit) predicts every
// output each cycle; directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_display_frame_latch;

   localparam int DEST_W   = 8;
   localparam int PEOPLE_W = 26;
   localparam int STATE_W  = 2;
   localparam int BLINK    = 30;

   logic                pixel_clk = 1'b0;
   logic                reset = 1'b1;
   logic                upd_valid = 1'b0;
   logic                upd_ready;
   logic [DEST_W-1:0]   upd_destination = '0;
   logic [PEOPLE_W-1:0] upd_people_data = '0;
   logic [STATE_W-1:0]  upd_sim_state = '0;
   logic                vsync = 1'b1;
   logic [DEST_W-1:0]   destination;
   logic [PEOPLE_W-1:0] people_data;
   logic [STATE_W-1:0]  sim_state;
   logic [7:0]          frame_count;
   logic                blink;
   logic [7:0]          stale_frames;

   always #20 pixel_clk = ~pixel_clk;

   display_frame_latch #(
      .DEST_W(DEST_W), .PEOPLE_W(PEOPLE_W), .STATE_W(STATE_W), .BLINK_FRAMES(BLINK)
   ) dut (
      .pixel_clk(pixel_clk), .reset(reset),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_destination(upd_destination), .upd_people_data(upd_people_data),
      .upd_sim_state(upd_sim_state), .vsync(vsync),
      .destination(destination), .people_data(people_data), .sim_state(sim_state),
      .frame_count(frame_count), .blink(blink), .stale_frames(stale_frames)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DEST_W-1:0]   m_pend_dest = '0, m_out_dest = '0;
   logic [PEOPLE_W-1:0] m_pend_people = '0, m_out_people = '0;
   logic [STATE_W-1:0]  m_pend_state = '0, m_out_state = '0;
   bit m_pend_valid = 0;
   bit m_ready = 0;
   bit m_prev_vsync = 1;
   int m_frames = 0;
   int m_since_commit = 0;
   bit m_accepted = 0;
   bit m_committed = 0;
   int txn = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: advance the model with the inputs present at the edge,
   // then compare every output 1 time unit after the edge.
   task automatic step();
      bit fs;
      @(posedge pixel_clk);
      m_accepted  = 0;
      m_committed = 0;
      if (reset) begin
         m_pend_valid = 0;
         m_out_dest = '0; m_out_people = '0; m_out_state = '0;
         m_pend_dest = '0; m_pend_people = '0; m_pend_state = '0;
         m_frames = 0; m_since_commit = 0;
         m_ready = 0; m_prev_vsync = 1;
      end else begin
         fs = m_prev_vsync && !vsync;
         if (fs && m_pend_valid) begin
            m_out_dest = m_pend_dest; m_out_people = m_pend_people; m_out_state = m_pend_state;
            m_pend_valid = 0;
            m_committed = 1;
         end
         if (upd_valid && m_ready) begin
            m_pend_dest = upd_destination; m_pend_people = upd_people_data;
            m_pend_state = upd_sim_state;
            m_pend_valid = 1;
            m_accepted = 1;
         end
         if (fs) begin
            m_frames++;
            if (m_committed) m_since_commit = 0;
            else m_since_commit++;
         end
         m_ready = !m_pend_valid;
         m_prev_vsync = vsync;
      end
      #1;
      chk("upd_ready", 32'(upd_ready), 32'(m_ready));
      chk("destination", 32'(destination), 32'(m_out_dest));
      chk("people_data", 32'(people_data), 32'(m_out_people));
      chk("sim_state", 32'(sim_state), 32'(m_out_state));
      chk("frame_count", 32'(frame_count), 32'(m_frames % 256));
      chk("blink", 32'(blink), 32'((m_frames / BLINK) % 2));
      chk("stale_frames", 32'(stale_frames),
          32'((m_since_commit > 255) ? 255 : m_since_commit));
      if (m_accepted) begin
         txn++;
         $display("txn %0d accept dest=0x%0h people=0x%0h state=%0d", txn,
                  m_pend_dest, m_pend_people, m_pend_state);
      end
      if (m_committed) begin
         txn++;
         $display("txn %0d commit dest=0x%0h people=0x%0h state=%0d frame=%0d", txn,
                  m_out_dest, m_out_people, m_out_state, m_frames % 256);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse();
      vsync = 1'b0; step(); step();
      vsync = 1'b1; step(); step(); step();
   endtask

   task automatic offer(input logic [DEST_W-1:0] d, input logic [PEOPLE_W-1:0] p,
                        input logic [STATE_W-1:0] s);
      upd_valid = 1'b1; upd_destination = d; upd_people_data = p; upd_sim_state = s;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1; upd_valid = 1'b0; vsync = 1'b1;
      idle(n);
      reset = 1'b0;
   endtask

   initial begin
      int vcnt;

      // Reset, then 100 idle cycles with vsync high
      do_reset(3);
      step();
      chk("ready_post_reset", 32'(upd_ready), 32'd1);
      idle(99);
      chk("idle_dest", 32'(destination), 32'd0);

      // Single update and commit
      offer(8'h05, 26'h0000123, 2'd2);
      step();
      chk("ready_after_accept", 32'(upd_ready), 32'd0);
      upd_valid = 1'b0;
      vsync = 1'b0; step();
      chk("t2_dest", 32'(destination), 32'h05);
      chk("t2_people", 32'(people_data), 32'h123);
      chk("t2_state", 32'(sim_state), 32'd2);
      chk("t2_frame", 32'(frame_count), 32'd1);
      chk("t2_stale", 32'(stale_frames), 32'd0);
      step();
      vsync = 1'b1; idle(3);

      // Offer while FULL: second update waits for the frame
      offer(8'h11, 26'h1ABCDEF, 2'd1);
      step();
      offer(8'h22, 26'h0055AA5, 2'd3);
      idle(3);
      chk("t3_hold_dest", 32'(destination), 32'h05);
      vsync = 1'b0; step();
      chk("t3_first_dest", 32'(destination), 32'h11);
      step();
      vsync = 1'b1; upd_valid = 1'b0; idle(3);
      pulse();
      chk("t3_second_dest", 32'(destination), 32'h22);

      // Accept coinciding with the first low vsync sample: no bypass
      offer(8'h33, 26'h0F0F0F0, 2'd1);
      vsync = 1'b0; step();
      chk("t5_no_bypass", 32'(destination), 32'h22);
      upd_valid = 1'b0; step();
      vsync = 1'b1; idle(3);
      pulse();
      chk("t5_next_frame", 32'(destination), 32'h33);

      // Pending update discarded by a one-cycle reset
      offer(8'h44, 26'h2222222, 2'd3);
      step();
      upd_valid = 1'b0;
      do_reset(1);
      step();
      pulse();
      chk("t6_dest", 32'(destination), 32'd0);
      chk("t6_ready", 32'(upd_ready), 32'd1);

      // 300 frames with no updates
      do_reset(2);
      step();
      for (int f = 0; f < 300; f++) pulse();
      chk("t4_frame_count", 32'(frame_count), 32'd44);
      chk("t4_blink", 32'(blink), 32'd0);
      chk("t4_stale", 32'(stale_frames), 32'd255);

      // Randomized traffic
      vcnt = 5;
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 399) == 0);
         if (vcnt == 0) begin
            vsync = ~vsync;
            vcnt  = vsync ? int'($urandom_range(2, 10)) : int'($urandom_range(0, 2));
         end else begin
            vcnt--;
         end
         if (m_accepted || !upd_valid) begin
            if ($urandom_range(0, 2) == 0)
               offer(DEST_W'($urandom), PEOPLE_W'($urandom), STATE_W'($urandom));
            else
               upd_valid = 1'b0;
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_frame_latch.md
# display_frame_latch

Frame-synchronous snapshot stage upstream of the VGA controller. It accepts elevator display state (destination, passenger bitmap, simulation state) through a valid/ready handshake and holds one pending update. It commits that update to the VGA controller's inputs only at the start of the vertical sync pulse, so a frame never shows a mix of two states. It also supplies frame-rate timing (frame counter, blink phase, staleness count) for display animation.

## Interface

Parameters:
- DEST_W, 8, width of destination
- PEOPLE_W, 26, width of people_data
- STATE_W, 2, width of sim_state
- BLINK_FRAMES, 30, frames per blink half-period; legal range 1..255

Ports:
- pixel_clk  in  1  sole clock, 25 MHz pixel clock
- reset  in  1  synchronous, active-high
- upd_valid  in  1  producer offers an update
- upd_ready  out  1  block can accept an update
- upd_destination  in  DEST_W  offered destination
- upd_people_data  in  PEOPLE_W  offered passenger bitmap
- upd_sim_state  in  STATE_W  offered simulation state
- vsync  in  1  active-low vertical sync from the VGA controller
- destination  out  DEST_W  committed destination, to VGA controller
- people_data  out  PEOPLE_W  committed bitmap, to VGA controller
- sim_state  out  STATE_W  committed state, to VGA controller
- frame_count  out  8  frames since reset, wraps
- blink  out  1  toggles every BLINK_FRAMES frames
- stale_frames  out  8  frames since last commit, saturating

One clock and one reset only. Reset is synchronous and active-high. All logic is clocked on pixel_clk rising edge.

## Operation

- vsync_q registers vsync; its reset value is 1.
- frame_start is 1 when vsync_q==1 and vsync==0. It is combinational on the current sample.
- Pending buffer FSM has two states:
  - EMPTY: upd_ready=1. On upd_valid, capture all three upd_* fields into the buffer and go to FULL.
  - FULL: upd_ready=0. upd_valid is ignored, and the producer must hold its data. On frame_start, copy the buffer to the outputs and go to EMPTY.
- No bypass. An update accepted in the same cycle as frame_start is stored in the buffer and committed at the next frame_start.
- Outputs change only on frame_start with the FSM in FULL, or on reset.
- frame_count increments by 1 on every frame_start and wraps from 255 to 0.
- Blink counter:
  - Increments on frame_start.
  - When it would reach BLINK_FRAMES, it clears to 0 and blink toggles.
- stale_frames:
  - Clears to 0 on a commit.
  - Otherwise increments on frame_start, saturating at 255.
- Reset values: upd_ready=0 while reset is high, then 1 on the first cycle after reset deasserts. destination, people_data, sim_state, frame_count, blink and stale_frames are all 0. Blink counter is 0. FSM is EMPTY. vsync_q is 1.
- Reset mid-operation discards any pending update. No commit occurs in a cycle where reset is high, even if frame_start is true.

## Timing

- Handshake: a transfer occurs on a rising edge where upd_valid && upd_ready. upd_ready is a registered function of FSM state.
- After acceptance at edge N, upd_ready is 0 from cycle N+1 until the edge following the next frame_start.
- Commit latency: if vsync is first sampled low at edge N (with vsync_q=1), outputs show the buffer contents from cycle N+1. At the same edge, frame_count, blink and stale_frames update, and upd_ready returns to 1.
- vsync held low for multiple cycles produces exactly one frame_start.
- Throughput: at most one commit per frame. The producer stalls if it updates faster than the frame rate.

## Test plan

- Reset, then hold vsync=1 for 100 cycles. Required: all outputs stay 0, and upd_ready=1 from the first post-reset cycle.
- Offer dest=0x05, people=0x0000123, state=2. Required: transfer in one cycle and upd_ready drops. Then pulse vsync low for 2 cycles: outputs show 0x05/0x0000123/2 exactly one cycle after the first low sample, frame_count=1, and stale_frames=0.
- Assert upd_valid with new data while FULL. Required: upd_ready=0 and the buffer stays unchanged. After frame_start, the first data is committed, then the second is accepted and committed at the following frame_start.
- Run 300 vsync pulses with BLINK_FRAMES=30 and no updates. Required: frame_count=44 (300 mod 256), blink toggles every 30 frames (final blink=0), and stale_frames=255.
- Make upd_valid coincide with the first low vsync sample while EMPTY. Required: outputs are unchanged that frame, and the data commits on the next frame_start.
- Load a pending update, then assert reset for 1 cycle, then send a vsync pulse. Required: outputs remain 0, upd_ready=1, and no commit.
